wb_initiator_seq: RTL and testbench
===================================

Name: wb_initiator_seq

Overview:
- Wishbone initiator (bus master) for the fabric's 17-bit-address / 32-bit-data register bus.
- Converts a command stream into single Wishbone read/write cycles toward FPGA-side register clients, such as the UART0 and FPGA register blocks.
- Returns read data and a timeout flag on a response stream.
- Used by the gateware test harness to exercise client register maps without going through the M4/AHB bridge.

Parameters:
- ADDRWIDTH, 17, Wishbone address width (byte address).
- DATAWIDTH, 32, Wishbone data width.
- TIMEOUT_CYCLES, 16, max cycles STB is held waiting for ACK before forced termination (must be ≥2).
- TIMEOUT_CNTR_WIDTH, 5, width of wait counter; must hold TIMEOUT_CYCLES.
- DEFAULT_READ_VALUE, 32'hBAD_FAB_AC, read data returned on timeout.

Ports:
- WB_CLK  input  1  bus clock; all logic on rising edge.
- WB_RST  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
- cmd_we  input  1  1=write, 0=read.
- cmd_adr  input  ADDRWIDTH  byte address.
- cmd_byte_stb  input  4  byte enables.
- cmd_wdat  input  DATAWIDTH  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdat  output  DATAWIDTH  captured read data (0 for writes).
- rsp_timeout  output  1  cycle ended by timeout.
- WBs_ADR  output  ADDRWIDTH  address.
- WBs_CYC  output  1  cycle.
- WBs_STB  output  1  strobe.
- WBs_WE  output  1  write enable.
- WBs_RD  output  1  read enable.
- WBs_BYTE_STB  output  4  byte select.
- WBs_WR_DAT  output  DATAWIDTH  write data.
- WBs_RD_DAT  input  DATAWIDTH  read data.
- WBs_ACK  input  1  client acknowledge.
- timeout_count  output  16  saturating count of timed-out cycles.

Behaviour:
- Reset values (synchronous):
  - All Wishbone outputs 0.
  - cmd_ready=1.
  - rsp_valid=0, rsp_rdat=0, rsp_timeout=0.
  - timeout_count=0.
  - Wait counter 0.
  - State IDLE.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept, register adr/byte_stb/we/wdat onto WBs_* outputs.
  - Next cycle: WBs_CYC=WBs_STB=1, WBs_WE=cmd_we, WBs_RD=~cmd_we.
  - Wait counter cleared. Go to BUS.
- BUS:
  - cmd_ready=0. All WBs_* outputs held stable.
  - If WBs_ACK=1 at an edge:
    - Capture rsp_rdat = WE ? 0 : WBs_RD_DAT, with rsp_timeout=0.
    - Next cycle: CYC/STB/WE/RD = 0, rsp_valid=1. Go to RESP.
  - Else the wait counter increments. When it reaches TIMEOUT_CYCLES-1 with no ACK:
    - Terminate identically, with rsp_rdat = WE ? 0 : DEFAULT_READ_VALUE and rsp_timeout=1.
    - timeout_count increments, saturating at 16'hFFFF.
  - ACK and timeout on the same edge: ACK wins (no timeout flagged, no count).
  - Minimum bus occupancy: 1 cycle (ACK in first STB cycle).
  - Maximum bus occupancy: TIMEOUT_CYCLES cycles.
- RESP:
  - cmd_ready=0. rsp_* held stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid=0 and return to IDLE, so cmd_ready=1 the following cycle.
  - Throughput: at most one transaction per 3 cycles (accept, ≥1 bus cycle, response handshake).
- WBs_ACK while CYC=0 is ignored; no state or data change.
- WBs_ADR, WBs_BYTE_STB and WBs_WR_DAT retain their last value when idle. They are only meaningful with CYC=1.
- WB_RST asserted in any state:
  - Next edge forces reset values and drops CYC/STB immediately.
  - An in-flight command or pending response is discarded without a response.
- rsp_ready held high does not bypass RESP; the response is visible for at least one cycle.

Test Plan:
- Write: cmd adr=17'h01000, byte_stb=4'hF, wdat=32'h0000_0041, we=1; client ACKs on 2nd STB cycle -> CYC/STB high exactly 2 cycles with stable adr/data, WE=1, RD=0; rsp_valid with rsp_rdat=0, rsp_timeout=0.
- Read: adr=17'h00000; client drives RD_DAT=32'h0000_0000 with ACK on 1st cycle -> CYC high 1 cycle, RD=1, WE=0; rsp_rdat=32'h0, rsp_timeout=0.
- Timeout: read adr=17'h12000, ACK never asserted, TIMEOUT_CYCLES=16 -> STB high exactly 16 cycles; rsp_rdat=32'hBAD_FAB_AC, rsp_timeout=1, timeout_count=1.
- ACK on the final timeout cycle (16th) with RD_DAT=32'h1234_5678 -> rsp_rdat=32'h1234_5678, rsp_timeout=0, timeout_count unchanged.
- Backpressure: rsp_ready=0 for 10 cycles after response, cmd_valid held high -> cmd_ready=0 throughout, rsp_* stable; second command accepted the cycle after rsp_ready=1 handshake plus one.
- Reset mid-cycle: assert WB_RST on 3rd BUS cycle -> next edge CYC=STB=0, rsp_valid=0, cmd_ready=1 after release; a stray ACK afterwards produces no response.

Source files
------------

// File: rtl/wb_initiator_seq_if.sv
// rtl/wb_initiator_seq_if.sv - command/response streams and Wishbone bus bundle for wb_initiator_seq
//
// Purpose: groups every handshake and bus signal of the initiator so the
// harness and the initiator connect through one bundle.
// Modports:
//   master - the initiator: consumes commands, produces responses, drives WBs_*.
//   slave  - the environment: produces commands, consumes responses, answers
//            the Wishbone cycle (WBs_RD_DAT / WBs_ACK).
interface wb_initiator_seq_if #(
    parameter int ADDRWIDTH = 17,
    parameter int DATAWIDTH = 32
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_we;
    logic [ADDRWIDTH-1:0] cmd_adr;
    logic [3:0]           cmd_byte_stb;
    logic [DATAWIDTH-1:0] cmd_wdat;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATAWIDTH-1:0] rsp_rdat;
    logic                 rsp_timeout;

    logic [ADDRWIDTH-1:0] WBs_ADR;
    logic                 WBs_CYC;
    logic                 WBs_STB;
    logic                 WBs_WE;
    logic                 WBs_RD;
    logic [3:0]           WBs_BYTE_STB;
    logic [DATAWIDTH-1:0] WBs_WR_DAT;
    logic [DATAWIDTH-1:0] WBs_RD_DAT;
    logic                 WBs_ACK;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_byte_stb, cmd_wdat,
        output cmd_ready,
        output rsp_valid, rsp_rdat, rsp_timeout,
        input  rsp_ready,
        output WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB, WBs_WR_DAT,
        input  WBs_RD_DAT, WBs_ACK
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_byte_stb, cmd_wdat,
        input  cmd_ready,
        input  rsp_valid, rsp_rdat, rsp_timeout,
        output rsp_ready,
        input  WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB, WBs_WR_DAT,
        output WBs_RD_DAT, WBs_ACK
    );
endinterface

// File: rtl/wb_initiator_seq.sv
// rtl/wb_initiator_seq.sv - Wishbone initiator turning a command stream into single bus cycles
//
// Purpose: accepts one command at a time, runs a single Wishbone read or write
// cycle, and returns the read data (0 for writes) plus a timeout flag on the
// response stream. A client that never acknowledges is cut off after
// TIMEOUT_CYCLES strobe cycles and DEFAULT_READ_VALUE is returned instead.
// Ports:
//   WB_CLK        bus clock, all logic on the rising edge
//   WB_RST        synchronous active-high reset
//   bus           wb_initiator_seq_if.master (cmd_*, rsp_*, WBs_*)
//   timeout_count saturating count of cycles that ended by timeout
module wb_initiator_seq #(
    parameter int          ADDRWIDTH          = 17,
    parameter int          DATAWIDTH          = 32,
    parameter int          TIMEOUT_CYCLES     = 16,
    parameter int          TIMEOUT_CNTR_WIDTH = 5,
    parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBAD_FAB_AC
) (
    input  logic                       WB_CLK,
    input  logic                       WB_RST,
    wb_initiator_seq_if.master         bus,
    output logic [15:0]                timeout_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Counter value seen on the last strobe cycle before forced termination.
    localparam logic [TIMEOUT_CNTR_WIDTH-1:0] WAIT_LAST = TIMEOUT_CNTR_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [DATAWIDTH-1:0]          DEF_RDAT  = DATAWIDTH'(DEFAULT_READ_VALUE);

    state_t                        state_q,         state_d;
    logic [TIMEOUT_CNTR_WIDTH-1:0] wait_cnt_q,      wait_cnt_d;
    logic                          cmd_ready_q,     cmd_ready_d;
    logic                          rsp_valid_q,     rsp_valid_d;
    logic [DATAWIDTH-1:0]          rsp_rdat_q,      rsp_rdat_d;
    logic                          rsp_timeout_q,   rsp_timeout_d;
    logic [ADDRWIDTH-1:0]          adr_q,           adr_d;
    logic                          cyc_q,           cyc_d;
    logic                          we_q,            we_d;
    logic                          rd_q,            rd_d;
    logic [3:0]                    byte_stb_q,      byte_stb_d;
    logic [DATAWIDTH-1:0]          wdat_q,          wdat_d;
    logic [15:0]                   timeout_count_q, timeout_count_d;

    always_comb begin
        state_d         = state_q;
        wait_cnt_d      = wait_cnt_q;
        cmd_ready_d     = cmd_ready_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_rdat_d      = rsp_rdat_q;
        rsp_timeout_d   = rsp_timeout_q;
        adr_d           = adr_q;
        cyc_d           = cyc_q;
        we_d            = we_q;
        rd_d            = rd_q;
        byte_stb_d      = byte_stb_q;
        wdat_d          = wdat_q;
        timeout_count_d = timeout_count_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    adr_d       = bus.cmd_adr;
                    byte_stb_d  = bus.cmd_byte_stb;
                    wdat_d      = bus.cmd_wdat;
                    we_d        = bus.cmd_we;
                    rd_d        = ~bus.cmd_we;
                    cyc_d       = 1'b1;
                    wait_cnt_d  = '0;
                    cmd_ready_d = 1'b0;
                    state_d     = S_BUS;
                end
            end

            S_BUS: begin
                // ACK is tested first so an acknowledge on the final allowed
                // cycle completes normally instead of being reported as a timeout.
                if (bus.WBs_ACK) begin
                    rsp_rdat_d    = we_q ? '0 : bus.WBs_RD_DAT;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    cyc_d         = 1'b0;
                    we_d          = 1'b0;
                    rd_d          = 1'b0;
                    state_d       = S_RESP;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    rsp_rdat_d    = we_q ? '0 : DEF_RDAT;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    cyc_d         = 1'b0;
                    we_d          = 1'b0;
                    rd_d          = 1'b0;
                    state_d       = S_RESP;
                    if (timeout_count_q != 16'hFFFF) begin
                        timeout_count_d = timeout_count_q + 16'd1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + TIMEOUT_CNTR_WIDTH'(1);
                end
            end

            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            state_q         <= S_IDLE;
            wait_cnt_q      <= '0;
            cmd_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            rsp_rdat_q      <= '0;
            rsp_timeout_q   <= 1'b0;
            adr_q           <= '0;
            cyc_q           <= 1'b0;
            we_q            <= 1'b0;
            rd_q            <= 1'b0;
            byte_stb_q      <= '0;
            wdat_q          <= '0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            wait_cnt_q      <= wait_cnt_d;
            cmd_ready_q     <= cmd_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdat_q      <= rsp_rdat_d;
            rsp_timeout_q   <= rsp_timeout_d;
            adr_q           <= adr_d;
            cyc_q           <= cyc_d;
            we_q            <= we_d;
            rd_q            <= rd_d;
            byte_stb_q      <= byte_stb_d;
            wdat_q          <= wdat_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    // Single cycles only, so STB always tracks CYC.
    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdat     = rsp_rdat_q;
    assign bus.rsp_timeout  = rsp_timeout_q;
    assign bus.WBs_ADR      = adr_q;
    assign bus.WBs_CYC      = cyc_q;
    assign bus.WBs_STB      = cyc_q;
    assign bus.WBs_WE       = we_q;
    assign bus.WBs_RD       = rd_q;
    assign bus.WBs_BYTE_STB = byte_stb_q;
    assign bus.WBs_WR_DAT   = wdat_q;
    assign timeout_count    = timeout_count_q;

endmodule

// File: tb/tb_wb_initiator_seq.sv
// tb/tb_wb_initiator_seq.sv - self-checking bench for wb_initiator_seq
module tb_wb_initiator_seq;

    localparam int          T   = 16;
    localparam logic [31:0] DEF = 32'hBAD_FAB_AC;

    logic        WB_CLK = 1'b0;
    logic        WB_RST;
    logic [15:0] timeout_count;

    int checks     = 0;
    int failures   = 0;
    int exp_tcount = 0;

    wb_initiator_seq_if bus ();

    wb_initiator_seq dut (
        .WB_CLK        (WB_CLK),
        .WB_RST        (WB_RST),
        .bus           (bus),
        .timeout_count (timeout_count)
    );

    always #5 WB_CLK = ~WB_CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one command end to end. ack_at: strobe cycle (1-based) in which the
    // client acknowledges; 0 or beyond T means it never does. Called just after
    // a falling edge; returns just after a falling edge with the DUT idle.
    task automatic do_txn(input logic we, input logic [16:0] adr, input logic [3:0] bs,
                          input logic [31:0] wdat, input int ack_at, input logic [31:0] rdat,
                          input int rsp_delay, input logic hold_valid);
        int          n;
        int          cyc_cnt;
        int          exp_cycles;
        logic        exp_to;
        logic [31:0] exp_rdat;

        exp_to     = !(ack_at >= 1 && ack_at <= T);
        exp_cycles = exp_to ? T : ack_at;
        exp_rdat   = we ? 32'h0 : (exp_to ? DEF : rdat);
        if (exp_to && exp_tcount < 65535) exp_tcount++;

        bus.cmd_we       = we;
        bus.cmd_adr      = adr;
        bus.cmd_byte_stb = bs;
        bus.cmd_wdat     = wdat;
        bus.cmd_valid    = 1'b1;
        bus.rsp_ready    = (rsp_delay == 0);

        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge WB_CLK);
            n++;
        end
        chk("accept_latency", n, 0);
        if (!bus.cmd_ready) begin
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge WB_CLK);
        @(negedge WB_CLK);
        bus.cmd_valid = hold_valid;

        cyc_cnt = 0;
        n = 0;
        while (bus.WBs_CYC && n < 40) begin
            cyc_cnt++;
            n++;
            chk("bus_stb",       bus.WBs_STB,      1);
            chk("bus_adr",       bus.WBs_ADR,      adr);
            chk("bus_we",        bus.WBs_WE,       we);
            chk("bus_rd",        bus.WBs_RD,       !we);
            chk("bus_byte_stb",  bus.WBs_BYTE_STB, bs);
            chk("bus_wdat",      bus.WBs_WR_DAT,   wdat);
            chk("bus_cmd_ready", bus.cmd_ready,    0);
            chk("bus_rsp_valid", bus.rsp_valid,    0);
            bus.WBs_ACK    = (cyc_cnt == ack_at);
            bus.WBs_RD_DAT = (cyc_cnt == ack_at) ? rdat : $urandom;
            @(negedge WB_CLK);
        end
        chk("bus_cycles", cyc_cnt, exp_cycles);

        for (int i = 0; i <= rsp_delay; i++) begin
            chk("rsp_valid",     bus.rsp_valid,   1);
            chk("rsp_rdat",      bus.rsp_rdat,    exp_rdat);
            chk("rsp_timeout",   bus.rsp_timeout, exp_to);
            chk("timeout_count", timeout_count,   exp_tcount);
            chk("rsp_cmd_ready", bus.cmd_ready,   0);
            chk("rsp_cyc",       bus.WBs_CYC,     0);
            bus.WBs_ACK   = 1'($urandom);   // stray ACK while CYC=0
            bus.rsp_ready = (i == rsp_delay);
            @(negedge WB_CLK);
        end
        bus.rsp_ready = 1'b0;
        bus.WBs_ACK   = 1'b0;
        chk("post_rsp_valid", bus.rsp_valid, 0);
        chk("post_cmd_ready", bus.cmd_ready, 1);
        chk("post_cyc",       bus.WBs_CYC,   0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        WB_RST           = 1'b1;
        bus.cmd_valid    = 1'b0;
        bus.cmd_we       = 1'b0;
        bus.cmd_adr      = '0;
        bus.cmd_byte_stb = '0;
        bus.cmd_wdat     = '0;
        bus.rsp_ready    = 1'b0;
        bus.WBs_RD_DAT   = '0;
        bus.WBs_ACK      = 1'b0;
        repeat (3) @(posedge WB_CLK);
        @(negedge WB_CLK);
        WB_RST = 1'b0;

        chk("reset_cmd_ready",   bus.cmd_ready,    1);
        chk("reset_cyc",         bus.WBs_CYC,      0);
        chk("reset_stb",         bus.WBs_STB,      0);
        chk("reset_we",          bus.WBs_WE,       0);
        chk("reset_rd",          bus.WBs_RD,       0);
        chk("reset_adr",         bus.WBs_ADR,      0);
        chk("reset_byte_stb",    bus.WBs_BYTE_STB, 0);
        chk("reset_wdat",        bus.WBs_WR_DAT,   0);
        chk("reset_rsp_valid",   bus.rsp_valid,    0);
        chk("reset_rsp_rdat",    bus.rsp_rdat,     0);
        chk("reset_rsp_timeout", bus.rsp_timeout,  0);
        chk("reset_tcount",      timeout_count,    0);

        // Directed cases
        do_txn(1'b1, 17'h01000, 4'hF, 32'h0000_0041, 2, 32'hDEAD_BEEF, 1, 1'b0);
        do_txn(1'b0, 17'h00000, 4'hF, 32'h0,         1, 32'h0000_0000, 0, 1'b0);
        do_txn(1'b0, 17'h12000, 4'hF, 32'h0,         0, 32'h0,         2, 1'b0);
        do_txn(1'b0, 17'h12004, 4'hF, 32'h0,         T, 32'h1234_5678, 0, 1'b0);
        do_txn(1'b1, 17'h12008, 4'h3, 32'hCAFE_F00D, 0, 32'h0,         1, 1'b0);
        do_txn(1'b0, 17'h00010, 4'hF, 32'h0,         3, 32'hA5A5_5A5A, 10, 1'b1);
        do_txn(1'b1, 17'h00014, 4'h1, 32'h0000_00FF, 1, 32'h0,         0, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            int   sel;
            int   ack_at;
            logic hold;
            sel = $urandom_range(0, 5);
            case (sel)
                0:       ack_at = 0;
                1:       ack_at = T;
                2:       ack_at = 1;
                3:       ack_at = T + 3;
                default: ack_at = $urandom_range(1, T);
            endcase
            hold = (k != 39) ? 1'($urandom) : 1'b0;
            do_txn(1'($urandom), 17'($urandom), 4'($urandom), $urandom, ack_at, $urandom,
                   $urandom_range(0, 4), hold);
        end
        bus.cmd_valid = 1'b0;

        // Reset on the 3rd strobe cycle of a read that would never be acknowledged
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = 17'h00100;
        bus.cmd_valid = 1'b1;
        @(posedge WB_CLK);
        @(negedge WB_CLK);
        bus.cmd_valid = 1'b0;
        chk("rst_mid_cyc_before", bus.WBs_CYC, 1);
        repeat (2) @(negedge WB_CLK);
        chk("rst_mid_cyc_3rd", bus.WBs_CYC, 1);
        WB_RST = 1'b1;
        @(posedge WB_CLK);
        @(negedge WB_CLK);
        chk("rst_mid_cyc",       bus.WBs_CYC,   0);
        chk("rst_mid_stb",       bus.WBs_STB,   0);
        chk("rst_mid_rsp_valid", bus.rsp_valid, 0);
        chk("rst_mid_tcount",    timeout_count, 0);
        WB_RST     = 1'b0;
        exp_tcount = 0;
        @(negedge WB_CLK);
        chk("rst_mid_cmd_ready", bus.cmd_ready, 1);
        bus.WBs_ACK    = 1'b1;
        bus.WBs_RD_DAT = 32'h7777_7777;
        for (int i = 0; i < 5; i++) begin
            @(negedge WB_CLK);
            chk("stray_ack_rsp_valid", bus.rsp_valid, 0);
            chk("stray_ack_cyc",       bus.WBs_CYC,   0);
            chk("stray_ack_rsp_rdat",  bus.rsp_rdat,  0);
        end
        bus.WBs_ACK = 1'b0;

        do_txn(1'b0, 17'h00200, 4'hF, 32'h0, 4, 32'h0BAD_C0DE, 1, 1'b0);
        do_txn(1'b0, 17'h00204, 4'hF, 32'h0, 0, 32'h0,         0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
